l2_block_server: RTL and testbench
==================================

// Module: l2_block_server
// PURPOSE
//  L2-side responder for one L1 data cache. Serves L1 block refills as a 16-word
//  burst and L1 word write-throughs from an internal word-addressed store.
//  Also forwards coherence flush requests to the L1 as a one-cycle flush pulse.
//  Sits directly downstream of L1_cache on its L2_* port group.
// PARAMETERS
//  n          32  data word width (bits)
//  block_size 16  words per block; power of two
//  ADDR_W     15  word address width; store depth = 2**ADDR_W words
//  READ_LAT   2   busy cycles between read accept and first data word (1..15)
//  WRITE_LAT  1   busy cycles between write accept and commit (1..15)
// PORTS
//  clk               in   1       rising-edge clock
//  reset             in   1       asynchronous, active-high reset
//  L2_read_request   in   1       L1 requests a block refill (level, held until served)
//  L2_write_request  in   1       L1 requests a word write (level, held until served)
//  L2_word_address   in   ADDR_W  word address from L1
//  L2_write_word     in   n       write data from L1
//  flush_req         in   1       coherence request to flush L1 (single-cycle pulse)
//  L2_read_word      out  n       burst data word to L1
//  L2_read_valid     out  1       L2_read_word carries a burst word this cycle
//  L2_busy           out  1       block cannot accept a request this cycle
//  flush             out  1       flush-all command to L1 (one-cycle pulse)
// BEHAVIOUR
//  Reset: state IDLE; L2_read_word=0, L2_read_valid=0, L2_busy=0, flush=0;
//   flush-pending flag and word counter cleared. Store is NOT cleared by reset.
//  Store init (time 0 only): mem[a] = a, zero-extended to n bits.
//  States: IDLE, RD_WAIT, STREAM, WR_WAIT, FLUSH. All outputs registered.
//  Requests are sampled only in IDLE. Priority: flush pending > write > read.
//  An unserved request is not latched; L1 holds it until L2_busy=0 in IDLE.
//  Read: accept at edge E0; latch base = addr & ~(block_size-1).
//   RD_WAIT for READ_LAT cycles, L2_busy=1.
//   STREAM for block_size cycles: L2_busy=0, L2_read_valid=1,
//   L2_read_word = mem[base+i], i=0..15 in ascending order (no critical-word-first).
//   After word 15: return to IDLE; L2_read_valid=0, L2_read_word=0.
//   First word is visible READ_LAT+1 cycles after E0.
//  Write: accept in IDLE; latch address and data; WR_WAIT for WRITE_LAT cycles, L2_busy=1.
//   mem updated on the final WR_WAIT edge; then IDLE.
//   A read accepted afterwards returns the new value.
//  Flush: a flush_req pulse in any state sets pending (repeat pulses while pending merge).
//   In IDLE with pending set: FLUSH for 1 cycle with flush=1 and L2_busy=1;
//   pending cleared; then IDLE.
//  Simultaneous read+write request in IDLE: write served first, read served after.
//  Address arithmetic: base+i never exceeds 2**ADDR_W-1, so there is no wrap within a burst.
//  Offset bits of a read address are ignored; write uses the full address.
//  Reset mid-operation: immediate return to reset values (async); the burst is abandoned;
//   a write still in WR_WAIT is dropped (store unchanged); pending flush is lost.
// TESTING
//  1 reset, read_req addr=1000 -> busy=1 for 2 cycles, then valid=1 for 16 cycles,
//    data 992..1007; then valid=0, busy=0.
//  2 write addr=1000 data=8 -> busy=1 for 1 cycle; next read of addr 995 returns
//    word 8 of the burst = 8, others = 992..1007.
//  3 read_req and write_req both high in IDLE (write addr=5 data=77) -> write first;
//    burst for block 0 then shows word5=77.
//  4 flush_req pulse during STREAM word 3 -> flush=1 exactly one cycle, the cycle after
//    word 15; no request accepted during that cycle.
//  5 reset asserted at STREAM word 5 -> valid, busy, flush low at once; a new read of
//    the same block gives the same data.
//  6 read addr=32767 -> burst 32752..32767; idle and ready for the next request.

Source files
------------

// File: rtl/l2_block_server.sv
// L2-side responder for one L1 data cache: 16-word block refills, word write-throughs,
// and forwarding of coherence flush requests as a one-cycle flush pulse.
module l2_block_server #(
  parameter int n          = 32,
  parameter int block_size = 16,
  parameter int ADDR_W     = 15,
  parameter int READ_LAT   = 2,
  parameter int WRITE_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              L2_read_request,
  input  logic              L2_write_request,
  input  logic [ADDR_W-1:0] L2_word_address,
  input  logic [n-1:0]      L2_write_word,
  input  logic              flush_req,
  output logic [n-1:0]      L2_read_word,
  output logic              L2_read_valid,
  output logic              L2_busy,
  output logic              flush
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int OFF_W = (block_size > 1) ? $clog2(block_size) : 1;
  localparam int CNT_W = (OFF_W > 4) ? OFF_W : 4;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(block_size - 1);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(block_size - 1);

  typedef enum logic [2:0] {IDLE, RD_WAIT, STREAM, WR_WAIT, FLUSH} state_t;
  typedef logic [n-1:0] store_t [DEPTH];

  function automatic store_t init_store();
    store_t s;
    for (int unsigned a = 0; a < DEPTH; a++) s[a] = n'(a);
    return s;
  endfunction

  // Power-up contents only; reset deliberately leaves the store alone.
  store_t mem = init_store();

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              pending, pending_n;
  logic [ADDR_W-1:0] base, base_n;
  logic [ADDR_W-1:0] wr_addr, wr_addr_n;
  logic [n-1:0]      wr_data, wr_data_n;
  logic              valid_n, busy_n, flush_n;
  logic              rd_load, mem_we, op_done;
  logic [ADDR_W-1:0] rd_addr;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    base_n    = base;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    pending_n = pending | flush_req;
    valid_n   = 1'b0;
    busy_n    = 1'b0;
    flush_n   = 1'b0;
    rd_load   = 1'b0;
    rd_addr   = base;
    mem_we    = 1'b0;
    op_done   = 1'b0;

    unique case (state)
      IDLE: begin
        if (pending) begin
          state_n   = FLUSH;
          pending_n = 1'b0;
          busy_n    = 1'b1;
          flush_n   = 1'b1;
        end else if (L2_write_request) begin
          state_n   = WR_WAIT;
          cnt_n     = CNT_W'(WRITE_LAT - 1);
          wr_addr_n = L2_word_address;
          wr_data_n = L2_write_word;
          busy_n    = 1'b1;
        end else if (L2_read_request) begin
          state_n = RD_WAIT;
          cnt_n   = CNT_W'(READ_LAT - 1);
          base_n  = L2_word_address & ~OFF_MASK;
          busy_n  = 1'b1;
        end
      end
      RD_WAIT: begin
        if (cnt == '0) begin
          state_n = STREAM;
          cnt_n   = '0;
          valid_n = 1'b1;
          rd_load = 1'b1;
          rd_addr = base;
        end else begin
          cnt_n  = cnt - 1'b1;
          busy_n = 1'b1;
        end
      end
      STREAM: begin
        if (cnt == LAST_IDX) begin
          op_done = 1'b1;
        end else begin
          cnt_n   = cnt + 1'b1;
          valid_n = 1'b1;
          rd_load = 1'b1;
          rd_addr = base + ADDR_W'(cnt_n);
        end
      end
      WR_WAIT: begin
        if (cnt == '0) begin
          mem_we  = 1'b1;
          op_done = 1'b1;
        end else begin
          cnt_n  = cnt - 1'b1;
          busy_n = 1'b1;
        end
      end
      FLUSH:   state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // A flush waiting behind a burst or write goes out on the very next cycle,
    // without an intervening idle cycle in which L1 requests could slip ahead.
    if (op_done) begin
      if (pending) begin
        state_n   = FLUSH;
        pending_n = 1'b0;
        busy_n    = 1'b1;
        flush_n   = 1'b1;
      end else begin
        state_n = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      pending       <= 1'b0;
      base          <= '0;
      wr_addr       <= '0;
      wr_data       <= '0;
      L2_read_word  <= '0;
      L2_read_valid <= 1'b0;
      L2_busy       <= 1'b0;
      flush         <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      pending       <= pending_n;
      base          <= base_n;
      wr_addr       <= wr_addr_n;
      wr_data       <= wr_data_n;
      L2_read_word  <= rd_load ? mem[rd_addr] : '0;
      L2_read_valid <= valid_n;
      L2_busy       <= busy_n;
      flush         <= flush_n;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_l2_block_server.sv
// Bench for l2_block_server: a per-cycle output schedule model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_l2_block_server;
  localparam int N  = 32;
  localparam int BS = 16;
  localparam int AW = 15;
  localparam int RL = 2;
  localparam int WL = 1;

  logic          clk = 1'b0, reset = 1'b0;
  logic          rreq = 1'b0, wreq = 1'b0, freq = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [N-1:0]  wdata = '0;
  logic [N-1:0]  rword;
  logic          rvalid, busy, flush;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  l2_block_server #(.n(N), .block_size(BS), .ADDR_W(AW), .READ_LAT(RL), .WRITE_LAT(WL)) dut (
    .clk(clk), .reset(reset),
    .L2_read_request(rreq), .L2_write_request(wreq),
    .L2_word_address(addr), .L2_write_word(wdata), .flush_req(freq),
    .L2_read_word(rword), .L2_read_valid(rvalid), .L2_busy(busy), .flush(flush)
  );

  task automatic chk(input string nm, input logic [63:0] g, input logic [63:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", nm, g, e, $time);
    end
  endtask

  // Model: a queue of the outputs each coming cycle must show, filled when a transaction starts.
  typedef struct packed { logic v; logic [N-1:0] w; logic b; logic f; } out_t;
  function automatic out_t mk(input logic v, input logic [N-1:0] w, input logic b, input logic f);
    out_t o;
    o.v = v; o.w = w; o.b = b; o.f = f;
    return o;
  endfunction

  out_t         plan[$];
  out_t         exp_cur = '0;
  logic [N-1:0] m_mem [int];
  logic         m_pend = 1'b0, m_wpend = 1'b0;
  int           m_waddr = 0;
  logic [N-1:0] m_wdata = '0;

  function automatic logic [N-1:0] mrd(input int a);
    if (m_mem.exists(a)) return m_mem[a];
    return N'(a);
  endfunction

  always @(posedge clk or posedge reset) begin : model
    int   base;
    logic took_flush;
    if (reset) begin
      plan.delete();
      exp_cur = '0;
      m_pend  = 1'b0;
      m_wpend = 1'b0;
    end else begin
      took_flush = 1'b0;
      if (m_wpend && plan.size() == 0) begin
        m_mem[m_waddr] = m_wdata;
        m_wpend = 1'b0;
      end
      if (plan.size() == 0) begin
        if (m_pend) begin
          plan.push_back(mk(1'b0, '0, 1'b1, 1'b1));
          took_flush = 1'b1;
        end else if (exp_cur == '0 && wreq) begin
          m_waddr = int'(addr);
          m_wdata = wdata;
          m_wpend = 1'b1;
          repeat (WL) plan.push_back(mk(1'b0, '0, 1'b1, 1'b0));
        end else if (exp_cur == '0 && rreq) begin
          base = int'(addr) & ~(BS - 1);
          repeat (RL) plan.push_back(mk(1'b0, '0, 1'b1, 1'b0));
          for (int i = 0; i < BS; i++) plan.push_back(mk(1'b1, mrd(base + i), 1'b0, 1'b0));
        end
      end
      if (plan.size() != 0) exp_cur = plan.pop_front();
      else exp_cur = '0;
      m_pend = took_flush ? 1'b0 : (m_pend | freq);
    end
  end

  always @(negedge clk) chk("cycle", {rvalid, rword, busy, flush}, exp_cur);

  logic [N-1:0] got [BS];
  int           busy_cnt;
  logic         vld_all;

  // Called at a negedge. Holds the read request until accepted, then collects the burst.
  task automatic do_read(input logic [AW-1:0] a, input int fl_at, input int rst_at);
    logic prev, accepted;
    int   k;
    addr = a; rreq = 1'b1;
    prev = busy; accepted = 1'b0; k = 0;
    while (!accepted && k < 40) begin
      @(negedge clk);
      k++;
      accepted = busy && !prev;
      prev = busy;
    end
    rreq = 1'b0;
    if (!accepted) begin
      chk("read_accept_timeout", 0, 1);
      return;
    end
    busy_cnt = 0;
    while (busy && busy_cnt < 40) begin
      busy_cnt++;
      @(negedge clk);
    end
    vld_all = 1'b1;
    for (int i = 0; i < BS; i++) begin
      got[i]  = rword;
      vld_all = vld_all & rvalid;
      freq    = (i == fl_at);
      if (i == rst_at) begin
        #1 reset = 1'b1;
        #1 chk("reset_mid_burst_outs", {rvalid, busy, flush}, 3'b000);
        return;
      end
      @(negedge clk);
    end
    freq = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs", {rvalid, rword, busy, flush}, '0);
    reset = 1'b0;
    @(negedge clk);

    // 1: plain refill of the block holding 1000
    do_read(15'd1000, -1, -1);
    chk("t1_busy_cycles", busy_cnt, 2);
    chk("t1_valid_all", vld_all, 1);
    for (int i = 0; i < BS; i++) chk("t1_word", got[i], 992 + i);
    chk("t1_after", {rvalid, rword, busy}, '0);

    // 2: write 8 to 1000, read back through address 995
    addr = 15'd1000; wdata = 32'd8; wreq = 1'b1;
    @(negedge clk);
    chk("t2_wr_busy", busy, 1);
    wreq = 1'b0;
    @(negedge clk);
    chk("t2_wr_done", busy, 0);
    do_read(15'd995, -1, -1);
    chk("t2_word8", got[8], 8);
    chk("t2_word0", got[0], 992);
    chk("t2_word15", got[15], 1007);

    // 3: simultaneous read and write, write wins
    addr = 15'd5; wdata = 32'd77; wreq = 1'b1; rreq = 1'b1;
    @(negedge clk);
    chk("t3_wr_first_busy", busy, 1);
    wreq = 1'b0;
    do_read(15'd5, -1, -1);
    chk("t3_word5", got[5], 77);
    chk("t3_word6", got[6], 6);

    // 4: flush pulse in STREAM word 3 appears right after word 15
    do_read(15'd64, 3, -1);
    chk("t4_words", {got[0], got[15]}, {32'd64, 32'd79});
    chk("t4_flush_cycle", {rvalid, busy, flush}, 3'b011);
    addr = 15'd64; rreq = 1'b1;
    @(negedge clk);
    chk("t4_no_accept_after_flush", {busy, flush}, 2'b00);
    do_read(15'd64, -1, -1);
    chk("t4_reread_word3", got[3], 67);

    // flush pulse while idle
    freq = 1'b1;
    @(negedge clk);
    freq = 1'b0;
    chk("idle_flush_wait", flush, 0);
    @(negedge clk);
    chk("idle_flush_pulse", {busy, flush}, 2'b11);
    @(negedge clk);
    chk("idle_flush_end", {busy, flush}, 2'b00);

    // 5: reset at STREAM word 5, then the same block again
    do_read(15'd1000, -1, 5);
    chk("t5_word5_before_reset", got[5], 997);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_read(15'd1000, -1, -1);
    chk("t5_word5", got[5], 997);
    chk("t5_word8", got[8], 8);

    // reset during WR_WAIT drops the write
    addr = 15'd2000; wdata = 32'hdead; wreq = 1'b1;
    @(negedge clk);
    chk("wr_drop_busy", busy, 1);
    wreq = 1'b0;
    #1 reset = 1'b1;
    #1 chk("wr_drop_reset_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_read(15'd2000, -1, -1);
    chk("wr_drop_word", got[0], 2000);

    // 6: top block of the store
    do_read(15'd32767, -1, -1);
    for (int i = 0; i < BS; i++) chk("t6_word", got[i], 32752 + i);
    chk("t6_idle", {rvalid, busy, flush}, 3'b000);
    do_read(15'd3, -1, -1);
    chk("t6_next_read", got[5], 77);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
